// File: rtl/npc_predictor.sv
`default_nettype none
// ============================================================================
// Module   : npc_predictor
// Brief    : IF-stage next-PC unit with static RV32 decode, a 2-bit BHT and a
//            resolve queue that redirects fetch and trains on mispredicts.
// Revision : 1.0
// ============================================================================
module npc_predictor #(
    parameter int WIDTH_PC      = 32,
    parameter int WIDTH_INST    = 32,
    parameter int RESOLVE_DEPTH = 2,
    parameter int BHT_ENTRIES   = 64,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stop_IF,
    input  logic [WIDTH_PC-1:0]   current_pc,
    input  logic [WIDTH_INST-1:0] inst,
    input  logic                  PCSel,
    input  logic [WIDTH_PC-1:0]   branch_pc,
    output logic [WIDTH_PC-1:0]   npc,
    output logic                  pred_taken,
    output logic                  risk_Ctrl,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam int         IDX         = $clog2(BHT_ENTRIES);
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    logic [1:0]          r_bht [BHT_ENTRIES];
    logic [RESOLVE_DEPTH-1:0] r_q_valid;
    logic [RESOLVE_DEPTH-1:0] r_q_pred;
    logic [RESOLVE_DEPTH-1:0] r_q_br;
    logic [IDX-1:0]      r_q_idx [RESOLVE_DEPTH];
    logic [CNT_WIDTH-1:0] r_mis_cnt;

    logic [20:0]         w_imm_j;
    logic [12:0]         w_imm_b;
    logic [WIDTH_PC-1:0] w_off_j;
    logic [WIDTH_PC-1:0] w_off_b;
    logic [IDX-1:0]      w_idx;
    logic                w_is_jal;
    logic                w_is_branch;
    logic                w_pred;
    logic [WIDTH_PC-1:0] w_target;
    logic                w_risk;
    logic                w_retire;

    assign w_imm_j     = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign w_imm_b     = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    // Signed size casts sign-extend or truncate to the PC width as needed.
    assign w_off_j     = WIDTH_PC'($signed(w_imm_j));
    assign w_off_b     = WIDTH_PC'($signed(w_imm_b));
    assign w_idx       = current_pc[IDX+1:2];
    assign w_is_jal    = (inst[6:0] == c_OP_JAL);
    assign w_is_branch = (inst[6:0] == c_OP_BRANCH);

    always_comb begin
        w_pred   = 1'b0;
        w_target = current_pc + WIDTH_PC'(4);
        if (w_is_jal) begin
            w_pred   = 1'b1;
            w_target = current_pc + w_off_j;
        end else if (w_is_branch) begin
            w_pred = r_bht[w_idx][1];
            if (r_bht[w_idx][1]) begin
                w_target = current_pc + w_off_b;
            end
        end
    end

    assign w_risk   = r_q_valid[0] && (PCSel != r_q_pred[0]);
    assign w_retire = r_q_valid[0] && (w_risk || !stop_IF);

    always_comb begin
        npc = w_target;
        if (w_risk) begin
            npc = branch_pc;
        end else if (stop_IF) begin
            npc = current_pc;
        end
    end

    assign pred_taken       = w_pred;
    assign risk_Ctrl        = w_risk;
    assign mispredict_count = r_mis_cnt;

    // Wrong-path fetch in a redirect cycle is dropped, not enqueued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_valid <= '0;
            r_q_pred  <= '0;
            r_q_br    <= '0;
            for (int i = 0; i < RESOLVE_DEPTH; i++) begin
                r_q_idx[i] <= '0;
            end
        end else if (w_risk) begin
            r_q_valid <= '0;
        end else if (!stop_IF) begin
            for (int i = 0; i < RESOLVE_DEPTH - 1; i++) begin
                r_q_valid[i] <= r_q_valid[i+1];
                r_q_pred[i]  <= r_q_pred[i+1];
                r_q_br[i]    <= r_q_br[i+1];
                r_q_idx[i]   <= r_q_idx[i+1];
            end
            r_q_valid[RESOLVE_DEPTH-1] <= 1'b1;
            r_q_pred[RESOLVE_DEPTH-1]  <= w_pred;
            r_q_br[RESOLVE_DEPTH-1]    <= w_is_branch;
            r_q_idx[RESOLVE_DEPTH-1]   <= w_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_retire && r_q_br[0]) begin
            if (PCSel && (r_bht[r_q_idx[0]] != 2'b11)) begin
                r_bht[r_q_idx[0]] <= r_bht[r_q_idx[0]] + 2'b01;
            end else if (!PCSel && (r_bht[r_q_idx[0]] != 2'b00)) begin
                r_bht[r_q_idx[0]] <= r_bht[r_q_idx[0]] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mis_cnt <= '0;
        end else if (w_risk && (r_mis_cnt != '1)) begin
            r_mis_cnt <= r_mis_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire
